// File: rtl/seq_mem_8x8b_1r1w_rf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mem_pkg
// Purpose  : Shared types and constants for the 8x8b 1r1w register-file
//            request controller (sizes, request-type codes, FSM state enum).
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package seq_mem_pkg;

  localparam int NUM_ENTRIES = 8;
  localparam int ADDR_NBITS  = 3;
  localparam int DATA_NBITS  = 8;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : seq_mem_pkg
`default_nettype wire

// File: rtl/seq_mem_8x8b_1r1w_rf_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_mem_8x8b_1r1w_rf_ctrl_if
// Purpose  : val/rdy memory request/response bus between upstream logic
//            (master) and the register-file controller (slave).
// Signals  : req_val/req_rdy/req_type/req_addr/req_data  request channel
//            resp_val/resp_rdy/resp_type/resp_data       response channel
// Revision : 1.0  initial release
// ============================================================================
interface seq_mem_8x8b_1r1w_rf_ctrl_if;

  logic                                  req_val;
  logic                                  req_rdy;
  logic                                  req_type;
  logic [seq_mem_pkg::ADDR_NBITS-1:0]    req_addr;
  logic [seq_mem_pkg::DATA_NBITS-1:0]    req_data;

  logic                                  resp_val;
  logic                                  resp_rdy;
  logic                                  resp_type;
  logic [seq_mem_pkg::DATA_NBITS-1:0]    resp_data;

  modport master (
    output req_val, req_type, req_addr, req_data, resp_rdy,
    input  req_rdy, resp_val, resp_type, resp_data
  );

  modport slave (
    input  req_val, req_type, req_addr, req_data, resp_rdy,
    output req_rdy, resp_val, resp_type, resp_data
  );

endinterface : seq_mem_8x8b_1r1w_rf_ctrl_if
`default_nettype wire

// File: rtl/seq_mem_8x8b_1r1w_rf_ctrl_resp_buf.sv
`default_nettype none
// ============================================================================
// Module   : seq_mem_rf_ctrl_resp_buf
// Purpose  : Single-entry val/rdy pipe register holding {type, data}.
//            Accepts a new entry in the same cycle the held one drains.
// Ports    : clk, reset                      clock / sync active-high reset
//            enq_val_i/enq_rdy_o/enq_*_i     enqueue side
//            deq_val_o/deq_rdy_i/deq_*_o     dequeue side
// Revision : 1.0  initial release
// ============================================================================
module seq_mem_rf_ctrl_resp_buf
  import seq_mem_pkg::*;
(
  input  wire                   clk,
  input  wire                   reset,
  input  wire                   enq_val_i,
  output logic                  enq_rdy_o,
  input  wire                   enq_type_i,
  input  wire [DATA_NBITS-1:0]  enq_data_i,
  output logic                  deq_val_o,
  input  wire                   deq_rdy_i,
  output logic                  deq_type_o,
  output logic [DATA_NBITS-1:0] deq_data_o
);

  logic                  full_q;
  logic                  type_q;
  logic [DATA_NBITS-1:0] data_q;

  assign enq_rdy_o  = !full_q || deq_rdy_i;
  assign deq_val_o  = full_q;
  assign deq_type_o = type_q;
  assign deq_data_o = data_q;

  // Enqueue has priority: a simultaneous drain + fill keeps the entry full
  // with the new contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      type_q <= 1'b0;
      data_q <= '0;
    end else if (enq_val_i && enq_rdy_o) begin
      full_q <= 1'b1;
      type_q <= enq_type_i;
      data_q <= enq_data_i;
    end else if (full_q && deq_rdy_i) begin
      full_q <= 1'b0;
    end
  end

endmodule : seq_mem_rf_ctrl_resp_buf
`default_nettype wire

// File: rtl/seq_mem_8x8b_1r1w_rf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_mem_8x8b_1r1w_rf_ctrl
// Purpose  : Requester-side controller for an 8-entry x 8-bit 1r1w register
//            file. Serves val/rdy read/write requests with a one-cycle
//            response through a single-entry response register.
// Option   : `define SEQ_MEM_8X8B_1R1W_RF_CTRL_INIT_EN to build the post-reset
//            sweep that writes INIT_VALUE to all entries before accepting
//            requests. Undefined: block resets straight into RUN.
// Ports    : clk, reset             clock / sync active-high reset
//            bus (slave)            request/response val/rdy bus
//            rf_read_addr/_data     register file read port (comb. read)
//            rf_write_en/_addr/_data register file write port
//            init_done              high while in RUN
// Revision : 1.0  initial release
// ============================================================================
module seq_mem_8x8b_1r1w_rf_ctrl
  import seq_mem_pkg::*;
#(
  parameter logic [DATA_NBITS-1:0] INIT_VALUE = 8'h00
) (
  input  wire                   clk,
  input  wire                   reset,
  seq_mem_8x8b_1r1w_rf_ctrl_if.slave bus,
  output logic [ADDR_NBITS-1:0] rf_read_addr,
  input  wire  [DATA_NBITS-1:0] rf_read_data,
  output logic                  rf_write_en,
  output logic [ADDR_NBITS-1:0] rf_write_addr,
  output logic [DATA_NBITS-1:0] rf_write_data,
  output logic                  init_done
);

  logic                  run;
  logic                  buf_enq_rdy;
  logic                  fire;
  logic [DATA_NBITS-1:0] enq_data;

`ifdef SEQ_MEM_8X8B_1R1W_RF_CTRL_INIT_EN
  localparam logic [ADDR_NBITS-1:0] LAST_ADDR = ADDR_NBITS'(NUM_ENTRIES - 1);

  state_e                state_q, state_d;
  logic [ADDR_NBITS-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign run = (state_q == RUN);
`else
  logic unused_init_value;
  assign unused_init_value = ^INIT_VALUE;
  assign run = 1'b1;
`endif

  // Pipe-through: a new request is accepted in the cycle the held response
  // drains, giving 1/cycle throughput with resp_rdy held high.
  assign bus.req_rdy  = run && buf_enq_rdy;
  assign fire         = bus.req_val && bus.req_rdy;
  assign init_done    = run;
  assign rf_read_addr = bus.req_addr;

  // Write responses carry zero data; reads capture the combinational
  // register-file output at the firing edge.
  assign enq_data = (bus.req_type == REQ_WRITE) ? '0 : rf_read_data;

  always_comb begin
    rf_write_en   = 1'b0;
    rf_write_addr = '0;
    rf_write_data = '0;
`ifdef SEQ_MEM_8X8B_1R1W_RF_CTRL_INIT_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      rf_write_en   = 1'b1;
      rf_write_addr = cnt_q;
      rf_write_data = INIT_VALUE;
      // Counter parks at the last address rather than wrapping.
      if (cnt_q == LAST_ADDR) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
`endif
    // fire is only possible in RUN, so this never collides with the sweep.
    if (fire && (bus.req_type == REQ_WRITE)) begin
      rf_write_en   = 1'b1;
      rf_write_addr = bus.req_addr;
      rf_write_data = bus.req_data;
    end
  end

  seq_mem_rf_ctrl_resp_buf u_resp_buf (
    .clk        (clk),
    .reset      (reset),
    .enq_val_i  (fire),
    .enq_rdy_o  (buf_enq_rdy),
    .enq_type_i (bus.req_type),
    .enq_data_i (enq_data),
    .deq_val_o  (bus.resp_val),
    .deq_rdy_i  (bus.resp_rdy),
    .deq_type_o (bus.resp_type),
    .deq_data_o (bus.resp_data)
  );

endmodule : seq_mem_8x8b_1r1w_rf_ctrl
`default_nettype wire
